ctr_selftest: RTL and testbench
===============================

// Module: ctr_selftest
// PURPOSE
//   Synthesizable on-chip self-test for the blinky counter. Drives the counter's
//   reset, then compares the counter output against an internal gold counter.
//   Reports pass/fail on the board with no simulator in the loop.
//   Sits beside `top`, sharing its clock, and owns top's reset input.
// PARAMETERS
//   WIDTH         8     width of the counter under test and of the gold counter
//   RST_CYCLES    5     cycles dut_rst is held high (must be >=1)
//   CHECK_CYCLES  500   number of compares per run (must be >=1)
//   ERR_W         16    width of the saturating mismatch counter
// PORTS
//   clk           in   1      single clock; also clocks the counter under test
//   rst_n         in   1      asynchronous, active-low reset
//   start         in   1      one-cycle pulse; begins a run from IDLE or DONE
//   dut_ctr       in   WIDTH  counter output under test (top.leds)
//   dut_rst       out  1      registered active-high reset to the counter under test
//   busy          out  1      high in RESET and CHECK
//   done          out  1      high in DONE; held until the next start
//   pass          out  1      valid while done: 1 = zero mismatches
//   err_cnt       out  ERR_W  mismatches seen in this run, saturating at all-ones
//   fail_idx      out  16     compare index (0-based) of the first mismatch
//   fail_gold     out  WIDTH  gold value at the first mismatch
//   fail_gate     out  WIDTH  dut_ctr value at the first mismatch
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; dut_rst=1; busy=0; done=0; pass=0.
//     Also clears err_cnt, fail_*, gold, and the cycle counter to 0.
//   FSM states: IDLE -> RESET -> CHECK -> DONE.
//   IDLE: dut_rst=1. start -> RESET. Cycle counter loads RST_CYCLES-1.
//   DONE: dut_rst=0. start -> RESET, same as from IDLE.
//   Run start (entering RESET): clears err_cnt, fail_*, gold, pass. done drops the same edge.
//   RESET: dut_rst=1 for exactly RST_CYCLES clock edges.
//     At terminal count -> CHECK; dut_rst goes 0 on that same edge.
//     The counter cycle sits at 0 during the first CHECK cycle.
//   CHECK: each edge compares dut_ctr to gold.
//     Then gold <= gold+1, wrapping modulo 2^WIDTH (255 -> 0 with WIDTH=8).
//     On a mismatch, err_cnt increments, holding at 2^ERR_W-1.
//     After CHECK_CYCLES compares -> DONE.
//     On that edge: done=1, pass = (err_cnt==0 && last compare matched).
//   start while busy is ignored. A run cannot be aborted except by rst_n.
//   rst_n asserted mid-run: everything returns to IDLE immediately, dut_rst=1.
//   dut_ctr is sampled directly. The counter under test shares clk, so no synchronizer is needed.
// CONFIGURATION
//   CTR_SELFTEST_CAPTURE_EN defined:
//     The first mismatch of a run loads fail_idx, fail_gold and fail_gate.
//     These hold until the next run start. Later mismatches do not overwrite them.
//     fail_idx saturates at 16'hFFFF.
//   CTR_SELFTEST_CAPTURE_EN undefined:
//     fail_* ports remain and are tied to 0. No capture registers are built.
//     err_cnt and pass behave identically in both builds.
// STRUCTURE
//   Package ctr_selftest_pkg holds:
//     - the state enum typedef (IDLE/RESET/CHECK/DONE);
//     - the default WIDTH/ERR_W constants.
//   Sub-module ctr_selftest_capture: first-mismatch capture registers.
//     Instantiated only under CTR_SELFTEST_CAPTURE_EN.
//   The FSM, cycle counter, gold counter and err_cnt stay in the top module.
// TESTING (bench instantiates top + ctr_selftest; period 20 ns)
//   1. rst_n low 100 ns, then high.
//      -> dut_rst=1, busy=0, done=0 throughout; counter output held at 0.
//   2. Pulse start.
//      -> dut_rst high exactly 5 edges; busy high 505 edges.
//      -> Then done=1, pass=1, err_cnt=0.
//   3. Force dut_ctr bit0 stuck at 0 for a whole run.
//      -> pass=0, err_cnt=250, fail_idx=1, fail_gold=8'h01, fail_gate=8'h00 (capture build).
//   4. CHECK_CYCLES=600, good counter.
//      -> gold wraps 255->0 with no mismatch; pass=1.
//   5. Assert rst_n mid-CHECK (compare 200).
//      -> same edge: state IDLE, dut_rst=1, busy=0.
//      -> A following start runs a full clean pass.
//   6. start pulsed while busy and again in DONE.
//      -> The in-run pulse is ignored.
//      -> The DONE pulse clears done/err_cnt and starts a fresh run.
//   Repeat scenario 3 without CTR_SELFTEST_CAPTURE_EN.
//      -> fail_*=0; err_cnt=250, pass=0.

Source files
------------

// File: rtl/ctr_selftest_pkg.sv
// Shared types and default sizes for the blinky-counter self-test.
package ctr_selftest_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 16;

endpackage

// File: rtl/ctr_selftest_capture.sv
// First-mismatch capture: records compare index, gold and gate values of the
// first mismatch of a run; cleared at each run start.
module ctr_selftest_capture
  import ctr_selftest_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             cmp_i,
  input  logic             mismatch_i,
  input  logic [WIDTH-1:0] gold_i,
  input  logic [WIDTH-1:0] gate_i,
  output logic [15:0]      fail_idx_o,
  output logic [WIDTH-1:0] fail_gold_o,
  output logic [WIDTH-1:0] fail_gate_o
);

  logic [15:0]      idx_q, idx_d;
  logic             seen_q, seen_d;
  logic [15:0]      fidx_q, fidx_d;
  logic [WIDTH-1:0] fgold_q, fgold_d;
  logic [WIDTH-1:0] fgate_q, fgate_d;

  always_comb begin
    idx_d   = idx_q;
    seen_d  = seen_q;
    fidx_d  = fidx_q;
    fgold_d = fgold_q;
    fgate_d = fgate_q;
    if (clear_i) begin
      idx_d   = '0;
      seen_d  = 1'b0;
      fidx_d  = '0;
      fgold_d = '0;
      fgate_d = '0;
    end else if (cmp_i) begin
      // Index saturates so a very long run still reports a bounded position.
      if (idx_q != 16'hFFFF) idx_d = idx_q + 16'd1;
      if (mismatch_i && !seen_q) begin
        seen_d  = 1'b1;
        fidx_d  = idx_q;
        fgold_d = gold_i;
        fgate_d = gate_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      seen_q  <= 1'b0;
      fidx_q  <= '0;
      fgold_q <= '0;
      fgate_q <= '0;
    end else begin
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      fidx_q  <= fidx_d;
      fgold_q <= fgold_d;
      fgate_q <= fgate_d;
    end
  end

  assign fail_idx_o  = fidx_q;
  assign fail_gold_o = fgold_q;
  assign fail_gate_o = fgate_q;

endmodule

// File: rtl/ctr_selftest.sv
// On-chip self-test for the blinky counter: resets it, then compares it with a
// gold counter. First-mismatch capture is built only with CTR_SELFTEST_CAPTURE_EN.
module ctr_selftest
  import ctr_selftest_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int RST_CYCLES   = 5,
  parameter int CHECK_CYCLES = 500,
  parameter int ERR_W        = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_ctr,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      fail_idx,
  output logic [WIDTH-1:0] fail_gold,
  output logic [WIDTH-1:0] fail_gate,
  output logic [1:0]       dbg_state
);

  // start is a single-cycle request accepted only in IDLE or DONE; there is no
  // ready: a pulse while busy is dropped, and done stays up until the next start.

  localparam int MAX_LOAD = (RST_CYCLES > CHECK_CYCLES) ? RST_CYCLES : CHECK_CYCLES;
  localparam int CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHK_LOAD = CNT_W'(CHECK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gold_q, gold_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             dut_rst_q, dut_rst_d;
  logic             run_start;
  logic             in_check;
  logic             mismatch;

  assign in_check = (state_q == S_CHECK);
  assign mismatch = in_check && (dut_ctr != gold_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gold_d    = gold_q;
    err_d     = err_q;
    pass_d    = pass_q;
    dut_rst_d = dut_rst_q;
    run_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        dut_rst_d = 1'b1;
        cnt_d     = RST_LOAD;
        run_start = start;
      end
      S_RESET: begin
        dut_rst_d = 1'b1;
        if (cnt_q == '0) begin
          // Release the counter on this edge so it reads 0 on the first compare.
          state_d   = S_CHECK;
          dut_rst_d = 1'b0;
          cnt_d     = CHK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: begin
        gold_d = gold_q + WIDTH'(1);
        if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        dut_rst_d = 1'b0;
        cnt_d     = RST_LOAD;
        run_start = start;
      end
      default: state_d = S_IDLE;
    endcase
    if (run_start) begin
      state_d   = S_RESET;
      dut_rst_d = 1'b1;
      gold_d    = '0;
      err_d     = '0;
      pass_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gold_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      dut_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gold_q    <= gold_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      dut_rst_q <= dut_rst_d;
    end
  end

  assign dut_rst   = dut_rst_q;
  assign busy      = (state_q == S_RESET) || in_check;
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

`ifdef CTR_SELFTEST_CAPTURE_EN
  ctr_selftest_capture #(
    .WIDTH(WIDTH)
  ) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (run_start),
    .cmp_i      (in_check),
    .mismatch_i (mismatch),
    .gold_i     (gold_q),
    .gate_i     (dut_ctr),
    .fail_idx_o (fail_idx),
    .fail_gold_o(fail_gold),
    .fail_gate_o(fail_gate)
  );
`else
  assign fail_idx  = '0;
  assign fail_gold = '0;
  assign fail_gate = '0;
`endif

endmodule

// File: tb/tb_ctr_selftest.sv
// Directed bench for ctr_selftest with a behavioural blinky counter beside it;
// expectations for fail_* follow CTR_SELFTEST_CAPTURE_EN.
`timescale 1ns/1ps
module tb_ctr_selftest;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start6;
  logic        stuck0;
  logic [7:0]  ctr_q  = 8'hAA;
  logic [7:0]  ctr6_q = 8'h55;
  logic [7:0]  gate, gate6;
  logic        dut_rst, busy, done, pass;
  logic [15:0] err_cnt, fail_idx;
  logic [7:0]  fail_gold, fail_gate;
  logic [1:0]  dbg_state;
  logic        dut_rst6, busy6, done6, pass6;
  logic [15:0] err_cnt6, fail_idx6;
  logic [7:0]  fail_gold6, fail_gate6;
  logic [1:0]  dbg_state6;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  always #10 clk = ~clk;

  // Counters under test: synchronous active-high reset from the self-test.
  always_ff @(posedge clk) ctr_q  <= dut_rst  ? 8'h00 : ctr_q  + 8'd1;
  always_ff @(posedge clk) ctr6_q <= dut_rst6 ? 8'h00 : ctr6_q + 8'd1;
  assign gate  = stuck0 ? {ctr_q[7:1], 1'b0} : ctr_q;
  assign gate6 = ctr6_q;

  ctr_selftest u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_ctr(gate),
    .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_gold(fail_gold),
    .fail_gate(fail_gate), .dbg_state(dbg_state)
  );

  ctr_selftest #(.CHECK_CYCLES(600)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .dut_ctr(gate6),
    .dut_rst(dut_rst6), .busy(busy6), .done(done6), .pass(pass6),
    .err_cnt(err_cnt6), .fail_idx(fail_idx6), .fail_gold(fail_gold6),
    .fail_gate(fail_gate6), .dbg_state(dbg_state6)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit which);
    if (which) start6 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start6 = 1'b0;
  endtask

  // Counts post-edge samples while busy; stops once busy falls or the budget runs out.
  task automatic measure(input bit which, output int busy_n, output int rst_n_cnt,
                         output int first_ctr, output bit timed_out);
    bit seen = 1'b0;
    busy_n = 0; rst_n_cnt = 0; first_ctr = -1; timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic b, r;
      logic [7:0] c;
      b = which ? busy6 : busy;
      r = which ? dut_rst6 : dut_rst;
      c = which ? gate6 : gate;
      if (!b) begin
        timed_out = 1'b0;
        break;
      end
      busy_n++;
      if (r) rst_n_cnt++;
      else if (!seen) begin
        first_ctr = int'(c);
        seen = 1'b1;
      end
      tick();
    end
  endtask

  int bn, rn, fc;
  bit to;

  initial begin
    rst_n = 1'b1; start = 1'b0; start6 = 1'b0; stuck0 = 1'b0;
    // 1: reset held for 100 ns
    #1 rst_n = 1'b0;
    #20;
    check_eq("rst_dut_rst_early", dut_rst, 1);
    check_eq("rst_busy_early", busy, 0);
    #50;
    check_eq("rst_dut_rst", dut_rst, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_fail_idx", fail_idx, 0);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_ctr_held", ctr_q, 0);
    #29 rst_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_dut_rst", dut_rst, 1);
    check_eq("idle_ctr_held", ctr_q, 0);
    check_eq("idle_done", done, 0);

    // 2: clean run
    pulse(1'b0);
    check_eq("start_busy", busy, 1);
    measure(1'b0, bn, rn, fc, to);
    exp_q.push_back(505); exp_q.push_back(5); exp_q.push_back(0);
    exp_q.push_back(1);   exp_q.push_back(1); exp_q.push_back(0);
    check_eq("run_busy_edges", bn, exp_q.pop_front());
    check_eq("run_rst_edges", rn, exp_q.pop_front());
    check_eq("run_first_ctr", fc, exp_q.pop_front());
    check_eq("run_done", done, exp_q.pop_front());
    check_eq("run_pass", pass, exp_q.pop_front());
    check_eq("run_err_cnt", err_cnt, exp_q.pop_front());
    check_eq("run_timeout", to, 0);
    repeat (3) tick();
    check_eq("done_held", done, 1);
    check_eq("done_dut_rst", dut_rst, 0);

    // 4: 600 compares, gold wraps twice
    pulse(1'b1);
    measure(1'b1, bn, rn, fc, to);
    check_eq("w600_busy_edges", bn, 605);
    check_eq("w600_timeout", to, 0);
    check_eq("w600_done", done6, 1);
    check_eq("w600_pass", pass6, 1);
    check_eq("w600_err_cnt", err_cnt6, 0);

    // 3: bit0 stuck at 0 for a whole run
    stuck0 = 1'b1;
    pulse(1'b0);
    measure(1'b0, bn, rn, fc, to);
    stuck0 = 1'b0;
    check_eq("stuck_timeout", to, 0);
    check_eq("stuck_done", done, 1);
    check_eq("stuck_pass", pass, 0);
    check_eq("stuck_err_cnt", err_cnt, 250);
`ifdef CTR_SELFTEST_CAPTURE_EN
    check_eq("stuck_fail_idx", fail_idx, 1);
    check_eq("stuck_fail_gold", fail_gold, 8'h01);
    check_eq("stuck_fail_gate", fail_gate, 8'h00);
`else
    check_eq("stuck_fail_idx", fail_idx, 0);
    check_eq("stuck_fail_gold", fail_gold, 0);
    check_eq("stuck_fail_gate", fail_gate, 0);
`endif

    // 6: start from DONE clears results; start while busy is ignored
    pulse(1'b0);
    check_eq("restart_done", done, 0);
    check_eq("restart_err_cnt", err_cnt, 0);
    check_eq("restart_busy", busy, 1);
    check_eq("restart_fail_idx", fail_idx, 0);
    repeat (100) tick();
    pulse(1'b0);
    measure(1'b0, bn, rn, fc, to);
    check_eq("ignore_busy_edges", bn, 404);
    check_eq("ignore_timeout", to, 0);
    check_eq("ignore_pass", pass, 1);
    check_eq("ignore_err_cnt", err_cnt, 0);

    // 5: async reset at compare 200, then a clean run
    pulse(1'b0);
    repeat (204) tick();
    check_eq("mid_state_check", dbg_state, 2);
    #5 rst_n = 1'b0;
    #1;
    check_eq("abort_state", dbg_state, 0);
    check_eq("abort_dut_rst", dut_rst, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse(1'b0);
    measure(1'b0, bn, rn, fc, to);
    check_eq("post_abort_busy_edges", bn, 505);
    check_eq("post_abort_first_ctr", fc, 0);
    check_eq("post_abort_timeout", to, 0);
    check_eq("post_abort_pass", pass, 1);
    check_eq("post_abort_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
